// File: rtl/apb_master_rr_arbiter.sv
// Two-requester APB master arbiter: round-robin grant onto one shared APB target,
// regenerated SETUP/ACCESS phases and an optional ACCESS-phase timeout.
module apb_master_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,

    input  logic [31:0] apb_request_0__paddr,
    input  logic        apb_request_0__penable,
    input  logic        apb_request_0__psel,
    input  logic        apb_request_0__pwrite,
    input  logic [31:0] apb_request_0__pwdata,

    input  logic [31:0] apb_request_1__paddr,
    input  logic        apb_request_1__penable,
    input  logic        apb_request_1__psel,
    input  logic        apb_request_1__pwrite,
    input  logic [31:0] apb_request_1__pwdata,

    output logic [31:0] apb_response_0__prdata,
    output logic        apb_response_0__pready,
    output logic        apb_response_0__perr,

    output logic [31:0] apb_response_1__prdata,
    output logic        apb_response_1__pready,
    output logic        apb_response_1__perr,

    output logic [31:0] apb_request__paddr,
    output logic        apb_request__penable,
    output logic        apb_request__psel,
    output logic        apb_request__pwrite,
    output logic [31:0] apb_request__pwdata,

    input  logic [31:0] apb_response__prdata,
    input  logic        apb_response__pready,
    input  logic        apb_response__perr,

    output logic [1:0]  grant,
    output logic        timeout_event
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] count_q, count_d;
    logic        timeout_event_q, timeout_event_d;

    logic        winner;
    logic        timeout_hit;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    // Requester penable carries no information: phases are regenerated here.
    logic unused_penable;
    assign unused_penable = apb_request_0__penable ^ apb_request_1__penable;

    assign timeout_hit = TIMEOUT_EN && (count_q == TIMEOUT_LAST);

    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        last_grant_d         = last_grant_q;
        count_d              = count_q;
        timeout_event_d      = 1'b0;
        winner               = 1'b0;
        resp_valid           = 1'b0;
        resp_data            = 32'd0;
        resp_err             = 1'b0;
        apb_request__psel    = 1'b0;
        apb_request__penable = 1'b0;
        apb_request__paddr   = 32'd0;
        apb_request__pwrite  = 1'b0;
        apb_request__pwdata  = 32'd0;

        if (state_q != IDLE) begin
            apb_request__paddr  = grant_q[1] ? apb_request_1__paddr  : apb_request_0__paddr;
            apb_request__pwrite = grant_q[1] ? apb_request_1__pwrite : apb_request_0__pwrite;
            apb_request__pwdata = grant_q[1] ? apb_request_1__pwdata : apb_request_0__pwdata;
        end

        case (state_q)
            IDLE: begin
                if (apb_request_0__psel || apb_request_1__psel) begin
                    // On a tie the requester that did not win last time goes first.
                    winner       = (apb_request_0__psel && apb_request_1__psel) ?
                                   ~last_grant_q : apb_request_1__psel;
                    grant_d      = winner ? 2'b10 : 2'b01;
                    last_grant_d = winner;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                apb_request__psel = 1'b1;
                count_d           = 16'd0;
                state_d           = ACCESS;
            end
            ACCESS: begin
                apb_request__psel    = 1'b1;
                apb_request__penable = 1'b1;
                if (apb_response__pready) begin
                    resp_valid = 1'b1;
                    resp_data  = apb_response__prdata;
                    resp_err   = apb_response__perr;
                    state_d    = IDLE;
                    grant_d    = 2'b00;
                end else begin
                    count_d = count_q + 16'd1;
                    if (timeout_hit) begin
                        resp_valid      = 1'b1;
                        resp_err        = 1'b1;
                        timeout_event_d = 1'b1;
                        state_d         = IDLE;
                        grant_d         = 2'b00;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // A requester that dropped psel mid-transfer gets nothing back.
    always_comb begin
        apb_response_0__pready = resp_valid && grant_q[0] && apb_request_0__psel;
        apb_response_1__pready = resp_valid && grant_q[1] && apb_request_1__psel;
        apb_response_0__prdata = apb_response_0__pready ? resp_data : 32'd0;
        apb_response_1__prdata = apb_response_1__pready ? resp_data : 32'd0;
        apb_response_0__perr   = apb_response_0__pready && resp_err;
        apb_response_1__perr   = apb_response_1__pready && resp_err;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            grant_q         <= 2'b00;
            last_grant_q    <= 1'b1;
            count_q         <= 16'd0;
            timeout_event_q <= 1'b0;
        end else if (clk__enable) begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            count_q         <= count_d;
            timeout_event_q <= timeout_event_d;
        end
    end

    assign grant         = grant_q;
    assign timeout_event = timeout_event_q;

endmodule

// File: tb/tb_apb_master_rr_arbiter.sv
// Directed bench for apb_master_rr_arbiter: stimulus pushes expected requester
// responses into a scoreboard queue that a negedge monitor pops and compares.
module tb_apb_master_rr_arbiter;

    typedef struct {
        bit          req;
        logic [31:0] prdata;
        bit          perr;
        bit          to;
    } exp_t;

    logic        clk, clk__enable, reset_n;
    logic [31:0] r0_paddr, r0_pwdata, r1_paddr, r1_pwdata;
    logic        r0_penable, r0_psel, r0_pwrite, r1_penable, r1_psel, r1_pwrite;
    logic [31:0] q0_prdata, q1_prdata;
    logic        q0_pready, q0_perr, q1_pready, q1_perr;
    logic [31:0] t_paddr, t_pwdata, t_prdata;
    logic        t_penable, t_psel, t_pwrite, t_pready, t_perr;
    logic [1:0]  grant;
    logic        timeout_event;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt0     = 0;
    int   cnt1     = 0;
    bit   te_pending = 1'b0;
    exp_t sb[$];

    apb_master_rr_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk                    (clk),
        .clk__enable            (clk__enable),
        .reset_n                (reset_n),
        .apb_request_0__paddr   (r0_paddr),
        .apb_request_0__penable (r0_penable),
        .apb_request_0__psel    (r0_psel),
        .apb_request_0__pwrite  (r0_pwrite),
        .apb_request_0__pwdata  (r0_pwdata),
        .apb_request_1__paddr   (r1_paddr),
        .apb_request_1__penable (r1_penable),
        .apb_request_1__psel    (r1_psel),
        .apb_request_1__pwrite  (r1_pwrite),
        .apb_request_1__pwdata  (r1_pwdata),
        .apb_response_0__prdata (q0_prdata),
        .apb_response_0__pready (q0_pready),
        .apb_response_0__perr   (q0_perr),
        .apb_response_1__prdata (q1_prdata),
        .apb_response_1__pready (q1_pready),
        .apb_response_1__perr   (q1_perr),
        .apb_request__paddr     (t_paddr),
        .apb_request__penable   (t_penable),
        .apb_request__psel      (t_psel),
        .apb_request__pwrite    (t_pwrite),
        .apb_request__pwdata    (t_pwdata),
        .apb_response__prdata   (t_prdata),
        .apb_response__pready   (t_pready),
        .apb_response__perr     (t_perr),
        .grant                  (grant),
        .timeout_event          (timeout_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input bit req, input logic [31:0] data, input bit err, input bit to);
        exp_t e;
        e.req = req; e.prdata = data; e.perr = err; e.to = to;
        sb.push_back(e);
    endtask

    // Monitor: pops one expected response per requester pready pulse.
    always @(negedge clk) begin
        exp_t e;
        if (te_pending || timeout_event)
            check("timeout_event", {31'd0, timeout_event}, {31'd0, te_pending});
        te_pending = 1'b0;
        if (q0_pready || q1_pready) begin
            if (sb.size() == 0) begin
                check("unexpected_pready", {30'd0, q1_pready, q0_pready}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_owner", {30'd0, q1_pready, q0_pready}, e.req ? 32'd2 : 32'd1);
                check("resp_prdata", e.req ? q1_prdata : q0_prdata, e.prdata);
                check("resp_perr", {31'd0, (e.req ? q1_perr : q0_perr)}, {31'd0, e.perr});
                te_pending = e.to;
                if (q1_pready) cnt1++;
                else cnt0++;
            end
        end else if ((q0_prdata | q1_prdata) != 32'd0 || q0_perr || q1_perr) begin
            check("idle_resp_zero", q0_prdata | q1_prdata | {30'd0, q1_perr, q0_perr}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        reset_n = 1'b0; clk__enable = 1'b1;
        r0_paddr = 0; r0_penable = 0; r0_psel = 0; r0_pwrite = 0; r0_pwdata = 0;
        r1_paddr = 0; r1_penable = 0; r1_psel = 0; r1_pwrite = 0; r1_pwdata = 0;
        t_prdata = 0; t_pready = 0; t_perr = 0;

        // Reset state
        #2;
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_target", {t_paddr | t_pwdata} | {29'd0, t_psel, t_penable, t_pwrite}, 32'd0);
        check("rst_resp", {29'd0, q0_pready | q1_pready, q0_perr | q1_perr, timeout_event}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single write from requester 0, zero-wait target
        r0_psel = 1; r0_pwrite = 1; r0_paddr = 32'h1004; r0_pwdata = 32'hdeadbeef; r0_penable = 1;
        t_pready = 1; t_prdata = 32'h0000_0001;
        expect_resp(0, 32'h0000_0001, 0, 0);
        @(negedge clk);
        check("c1_psel", {31'd0, t_psel}, 32'd0);
        check("c1_grant", {30'd0, grant}, 32'd0);
        tick();
        @(negedge clk);
        check("c2_psel_penable", {30'd0, t_psel, t_penable}, 32'd2);
        check("c2_grant", {30'd0, grant}, 32'd1);
        check("c2_paddr", t_paddr, 32'h1004);
        check("c2_pwdata", t_pwdata, 32'hdeadbeef);
        check("c2_pwrite", {31'd0, t_pwrite}, 32'd1);
        tick();
        @(negedge clk);
        check("c3_psel_penable", {30'd0, t_psel, t_penable}, 32'd3);
        check("c3_grant", {30'd0, grant}, 32'd1);
        tick();
        r0_psel = 0; r0_penable = 0;
        @(negedge clk);
        check("c4_grant", {30'd0, grant}, 32'd0);
        check("c4_psel", {31'd0, t_psel}, 32'd0);

        // Tie after reset: strict 0,1,0,1 alternation
        tick();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        c0 = cnt0; c1 = cnt1;
        r0_paddr = 32'h100; r1_paddr = 32'h200; r0_pwrite = 0; r1_pwrite = 0;
        r0_psel = 1; r1_psel = 1;
        for (int i = 0; i < 4; i++) begin
            expect_resp(i[0], 32'h1000 + i, 0, 0);
            tick();
            t_prdata = 32'h1000 + i;
            @(negedge clk);
            check("tie_grant", {30'd0, grant}, i[0] ? 32'd2 : 32'd1);
            check("tie_paddr", t_paddr, i[0] ? 32'h200 : 32'h100);
            tick();
            tick();
        end
        r0_psel = 0; r1_psel = 0;
        @(negedge clk);
        check("tie_cnt0", cnt0 - c0, 32'd2);
        check("tie_cnt1", cnt1 - c1, 32'd2);

        // Wait states: requester 1 read, ready on the fifth ACCESS cycle
        t_pready = 0; t_prdata = 0;
        r1_psel = 1; r1_paddr = 32'h2000; r1_pwrite = 0;
        expect_resp(1, 32'h12345678, 1, 0);
        tick();                                  // SETUP
        for (int i = 0; i < 4; i++) tick();      // ACCESS 1..4
        @(negedge clk);
        check("ws_penable", {31'd0, t_penable}, 32'd1);
        tick();                                  // ACCESS 5
        t_pready = 1; t_prdata = 32'h12345678; t_perr = 1;
        tick();
        r1_psel = 0; t_pready = 0; t_perr = 0; t_prdata = 0;
        @(negedge clk);
        check("ws_grant_after", {30'd0, grant}, 32'd0);

        // Timeout with a frozen window in the middle of ACCESS
        r0_psel = 1; r0_paddr = 32'h3000;
        expect_resp(0, 32'd0, 1, 1);
        tick();                                  // SETUP
        for (int i = 0; i < 3; i++) tick();      // ACCESS 1..3
        clk__enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("freeze_state", {29'd0, grant, t_penable}, 32'h3);
        end
        clk__enable = 1;
        for (int i = 0; i < 5; i++) tick();      // ACCESS 4..8, forced completion in 8
        tick();
        @(negedge clk);
        check("to_psel_after", {31'd0, t_psel}, 32'd0);
        r0_psel = 0;
        tick();

        // Timeout boundary: target ready on ACCESS cycle 8 wins
        r1_psel = 1; r1_paddr = 32'h4000;
        expect_resp(1, 32'hcafe0008, 0, 0);
        for (int i = 0; i < 8; i++) tick();      // SETUP, ACCESS 1..7
        tick();                                  // ACCESS 8
        t_pready = 1; t_prdata = 32'hcafe0008; t_perr = 0;
        tick();
        r1_psel = 0; t_pready = 0; t_prdata = 0;
        tick();

        // Reset during ACCESS
        r1_psel = 1; r1_paddr = 32'h5000;
        tick();                                  // SETUP
        tick();                                  // ACCESS 1
        reset_n = 0;
        #1;
        check("rst_mid_bus", {30'd0, t_psel, t_penable}, 32'd0);
        check("rst_mid_grant", {30'd0, grant}, 32'd0);
        r1_psel = 0;
        tick();
        reset_n = 1;
        r0_psel = 1; r1_psel = 1; r0_paddr = 32'h6000;
        t_pready = 1; t_prdata = 32'h66;
        expect_resp(0, 32'h66, 0, 0);
        tick();
        @(negedge clk);
        check("post_rst_grant", {30'd0, grant}, 32'd1);
        tick();
        tick();
        r0_psel = 0; r1_psel = 0; t_pready = 0;
        tick();
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
